// File: rtl/register_file_pkg.sv
// Shared types and sizing for the 8-entry datapath register file.
package register_file_pkg;

    localparam int REG_ADDR_BITS = 3;
    localparam int NUM_REGS      = 8;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } regfile_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: storage select with same-cycle write bypass.
module regfile_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int NUM_REGS  = 8
) (
    input  logic [NUM_REGS-1:0][DATA_BITS-1:0] i_regs,
    input  logic [REG_ADDR_BITS-1:0]           i_raddr,
    input  logic                               i_byp_en,
    input  logic [REG_ADDR_BITS-1:0]           i_waddr,
    input  logic [DATA_BITS-1:0]               i_wdata,
    output logic [DATA_BITS-1:0]               o_rdata
);

    logic w_hit;

    // Forward the in-flight write so a same-index reader never sees stale data.
    assign w_hit   = i_byp_en && (i_raddr == i_waddr);
    assign o_rdata = w_hit ? i_wdata : i_regs[i_raddr];

endmodule

// File: rtl/register_file.sv
// 8-entry register file: one write port, two bypassed read ports, sequenced clear.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int NUM_REGS  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_we,
    input  logic [REG_ADDR_BITS-1:0] i_waddr,
    input  logic [DATA_BITS-1:0]     i_wdata,
    input  logic [REG_ADDR_BITS-1:0] i_raddr_a,
    input  logic [REG_ADDR_BITS-1:0] i_raddr_b,
    output logic [DATA_BITS-1:0]     o_rdata_a,
    output logic [DATA_BITS-1:0]     o_rdata_b,
    input  logic                     i_clear_req,
    output logic                     o_clear_busy,
    output logic                     o_clear_done
);

    localparam int NUM_RD_PORTS = 2;

    regfile_state_t                      r_state;
    regfile_state_t                      w_next_state;
    logic [REG_ADDR_BITS-1:0]            r_clr_cnt;
    logic [NUM_REGS-1:0][DATA_BITS-1:0]  r_regs;
    logic                                w_wr_en;
    logic                                w_clr_last;

    logic [NUM_RD_PORTS-1:0][REG_ADDR_BITS-1:0] w_raddr;
    logic [NUM_RD_PORTS-1:0][DATA_BITS-1:0]     w_rdata;

    // Writes (and therefore bypass) are only live while no clear is in flight.
    assign w_wr_en    = i_we && (r_state == IDLE);
    assign w_clr_last = (r_clr_cnt == REG_ADDR_BITS'(NUM_REGS - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_clear_req) w_next_state = CLEAR;
            CLEAR:   if (w_clr_last)  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_clr_cnt <= '0;
        end else if (r_state == IDLE && i_clear_req) begin
            r_clr_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_cnt <= r_clr_cnt + REG_ADDR_BITS'(1);
        end
    end

    // A write landing on the clear-request edge still commits; the sweep zeroes it later.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_regs <= '0;
        end else if (r_state == CLEAR) begin
            r_regs[r_clr_cnt] <= '0;
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_clear_busy = (r_state == CLEAR);
    assign o_clear_done = (r_state == DONE);

    assign w_raddr[0] = i_raddr_a;
    assign w_raddr[1] = i_raddr_b;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        regfile_read_port #(
            .DATA_BITS (DATA_BITS),
            .NUM_REGS  (NUM_REGS)
        ) u_rd (
            .i_regs   (r_regs),
            .i_raddr  (w_raddr[p]),
            .i_byp_en (w_wr_en),
            .i_waddr  (i_waddr),
            .i_wdata  (i_wdata),
            .o_rdata  (w_rdata[p])
        );
    end

    assign o_rdata_a = w_rdata[0];
    assign o_rdata_b = w_rdata[1];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: cycle-level reference model plus directed literal checks.
module tb_register_file;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       reset = 1'b0;
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] raddr_a = '0;
    logic [2:0] raddr_b = '0;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic       clear_req = 1'b0;
    logic       clear_busy;
    logic       clear_done;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    register_file dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_we         (we),
        .i_waddr      (waddr),
        .i_wdata      (wdata),
        .i_raddr_a    (raddr_a),
        .i_raddr_b    (raddr_b),
        .o_rdata_a    (rdata_a),
        .o_rdata_b    (rdata_b),
        .i_clear_req  (clear_req),
        .o_clear_busy (clear_busy),
        .o_clear_done (clear_done)
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: storage array, remaining clear cycles, done flag.
    logic [7:0] m_regs [8];
    int         m_left = 0;
    bit         m_done = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= 8'h00;
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_regs[8 - m_left] <= 8'h00;
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
        end else if (m_done) begin
            m_done <= 1'b0;
        end else begin
            if (we) m_regs[waddr] <= wdata;
            if (clear_req) m_left <= 8;
        end
    end

    logic [7:0] e_a, e_b;
    bit         m_idle;

    always @(negedge clk) begin
        if (cmp_en) begin
            m_idle = (m_left == 0) && !m_done && !reset;
            e_a = (m_idle && we && raddr_a == waddr) ? wdata : m_regs[raddr_a];
            e_b = (m_idle && we && raddr_b == waddr) ? wdata : m_regs[raddr_b];
            chk("cyc_rdata_a", 32'(rdata_a), 32'(e_a));
            chk("cyc_rdata_b", 32'(rdata_b), 32'(e_b));
            chk("cyc_busy", 32'(clear_busy), 32'(m_left > 0 && !reset));
            chk("cyc_done", 32'(clear_done), 32'(m_done && !reset));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = v;
            tick();
        end
        we = 1'b0;
    endtask

    task automatic sweep_zero(input string nm);
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            #1;
            chk({nm, "_a"}, 32'(rdata_a), 32'h0);
            chk({nm, "_b"}, 32'(rdata_b), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int busy_n, done_n;

    initial begin
        // Reset with the clock stopped: reads must already be zero.
        #1 reset = 1'b1;
        #1;
        sweep_zero("rst_rd");
        chk("rst_busy", 32'(clear_busy), 32'h0);
        chk("rst_done", 32'(clear_done), 32'h0);
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        cmp_en = 1'b1;

        // Basic write then crossed reads.
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = 8'(17 * i);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            #1;
            chk("basic_a", 32'(rdata_a), 32'(17 * i));
            chk("basic_b", 32'(rdata_b), 32'(17 * (7 - i)));
            tick();
        end

        // Bypass on both ports, then a non-matching port reads old storage.
        we = 1'b1; waddr = 3'd3; wdata = 8'h20;
        tick();
        we = 1'b1; waddr = 3'd3; wdata = 8'hA5; raddr_a = 3'd3; raddr_b = 3'd3;
        #1;
        chk("byp_a", 32'(rdata_a), 32'hA5);
        chk("byp_b", 32'(rdata_b), 32'hA5);
        raddr_b = 3'd4;
        #1;
        chk("byp_other_b", 32'(rdata_b), 32'h44);
        tick();
        we = 1'b0; raddr_b = 3'd3;
        #1;
        chk("byp_after_a", 32'(rdata_a), 32'hA5);
        chk("byp_after_b", 32'(rdata_b), 32'hA5);
        tick();

        // Clear sequence with an ignored write to reg7 mid-sweep.
        fill(8'hFF);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        busy_n = 0; done_n = 0;
        for (int c = 0; c < 12; c++) begin
            raddr_a = 3'((c + 7) % 8);
            raddr_b = 3'(c % 8);
            #1;
            if (clear_busy) busy_n++;
            if (clear_done) done_n++;
            if (c >= 1 && c <= 8) chk("clr_done_idx", 32'(rdata_a), 32'h0);
            if (c <= 7) chk("clr_pending_idx", 32'(rdata_b), 32'hFF);
            we = (c == 3); waddr = 3'd7; wdata = 8'h55;
            tick();
            we = 1'b0;
        end
        chk("clr_busy_cycles", 32'(busy_n), 32'd8);
        chk("clr_done_cycles", 32'(done_n), 32'd1);
        sweep_zero("clr_end");
        tick();

        // Held request: two back-to-back sequences with one idle cycle between.
        clear_req = 1'b1;
        busy_n = 0; done_n = 0;
        for (int j = 1; j <= 24; j++) begin
            tick();
            if (j == 12) clear_req = 1'b0;
            #1;
            if (clear_busy) busy_n++;
            if (clear_done) done_n++;
            if (j == 9)  chk("held_done_j9", 32'(clear_done), 32'h1);
            if (j == 10) chk("held_gap_j10", 32'(clear_busy), 32'h0);
            if (j == 11) chk("held_restart_j11", 32'(clear_busy), 32'h1);
        end
        chk("held_busy_cycles", 32'(busy_n), 32'd16);
        chk("held_done_cycles", 32'(done_n), 32'd2);

        // Reset in the middle of a clear.
        fill(8'hFF);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (3) tick();
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(clear_busy), 32'h0);
        chk("mid_rst_done", 32'(clear_done), 32'h0);
        sweep_zero("mid_rst_rd");
        tick();
        reset = 1'b0;
        done_n = 0;
        for (int j = 0; j < 10; j++) begin
            #1;
            if (clear_done) done_n++;
            tick();
        end
        chk("mid_rst_no_done", 32'(done_n), 32'd0);
        we = 1'b1; waddr = 3'd2; wdata = 8'h3C;
        tick();
        we = 1'b0; raddr_a = 3'd2;
        #1;
        chk("post_rst_write", 32'(rdata_a), 32'h3C);
        tick();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 8-entry general-purpose register file for the datapath: one write port and two combinational read ports (A, B).
- Covers both directions of register access: write-address decode into storage, and read-address selection out of storage.
- Adds same-cycle write-to-read bypass and a sequenced clear engine that zeroes all registers, one per cycle, on request.
- Sits between the decode/ALU stage and write-back.

Parameters:
- DATA_BITS, 8, width of each register and of the data ports.
- NUM_REGS, 8, register count; fixed to 8 by the 3-bit addresses.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  write enable, sampled on the clk rising edge.
- waddr  input  3  write register index.
- wdata  input  DATA_BITS  write data.
- raddr_a  input  3  read port A register index.
- raddr_b  input  3  read port B register index.
- rdata_a  output  DATA_BITS  read port A data (combinational).
- rdata_b  output  DATA_BITS  read port B data (combinational).
- clear_req  input  1  request to zero all registers; level-sampled.
- clear_busy  output  1  high while the clear sequence runs.
- clear_done  output  1  one-cycle pulse when the clear sequence finishes.

Behaviour:
- Reset (async, active-high):
  - all registers 0; FSM to IDLE; clear counter 0; clear_busy 0; clear_done 0.
  - rdata_a/rdata_b read 0 once reset asserts.
- Write:
  - At the rising edge, if we=1 and state=IDLE, reg[waddr] <= wdata.
  - Writes are ignored in CLEAR and DONE; there is no stall or retry.
- Read: rdata_x = reg[raddr_x], combinational, zero-latency.
- Bypass:
  - If we=1, state=IDLE and raddr_x==waddr, rdata_x = wdata in the same cycle.
  - Applies independently to A and B; both ports may bypass at once.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clear_req=1 at the edge; counter <= 0.
    - A write with we=1 in that same cycle still commits.
    - The clear sequence then overwrites it with 0.
  - CLEAR: each edge sets reg[counter] <= 0 and counter <= counter+1.
    - After clearing index 7, go to DONE.
    - Counter is 3 bits and wraps to 0; no overflow flag.
  - DONE: one cycle, then IDLE.
  - clear_busy = (state==CLEAR).
  - clear_done = (state==DONE), a registered-state decode with no combinational path from inputs.
- Clear timing: clear_req sampled at edge N gives clear_busy high for edges N+1..N+8 and clear_done high in the cycle after edge N+8.
  - Total: 8 cycles busy, then 1 cycle done.
- Reads during CLEAR return current storage, so already-cleared entries read 0 and pending entries read their old values. Bypass is disabled.
- clear_req while in CLEAR or DONE is ignored, not queued.
  - If clear_req is still high in IDLE after DONE, a new sequence starts.
- Reset asserted mid-clear: immediate return to IDLE with all registers 0; no clear_done pulse.
- Same-cycle write and read of different indices: the read returns the old stored value of its own index.
- No register is hardwired to zero.

Decomposition:
- Shared package:
  - regfile_state_t enum {IDLE, CLEAR, DONE};
  - REG_ADDR_BITS=3;
  - NUM_REGS=8.
- One natural sub-module: regfile_read_port.
  - Inputs: storage array, raddr, bypass enable, waddr, wdata.
  - Instantiated twice, for A and B.
- Storage and clear FSM stay in the top module.

Test Plan:
- Reset check: assert reset mid-cycle with no clock; sweep raddr_a/raddr_b over 0..7 -> all reads 0, clear_busy=0, clear_done=0.
- Basic write/read: write 0x11*i to reg i for i=0..7, then read A=i, B=7-i -> rdata_a=0x11*i and rdata_b=0x11*(7-i).
- Bypass: reg3=0x20; drive we=1, waddr=3, wdata=0xA5, raddr_a=3, raddr_b=3 -> both read 0xA5 in that same cycle and 0xA5 after the edge. Also raddr_b=4 -> old reg4 value.
- Clear sequence: fill all registers with 0xFF, pulse clear_req for one cycle.
  - clear_busy is high for exactly 8 cycles, then clear_done for 1 cycle.
  - reg k reads 0 from the edge after busy-cycle k; all reads 0 at the end.
  - A write of 0x55 to reg7 during busy is ignored, and reg7 ends at 0.
- Held clear_req: hold clear_req=1 for 12 cycles -> a second sequence starts in the IDLE cycle after DONE, and there is no extra pulse mid-sequence.
- Reset mid-clear: fill registers with 0xFF, start a clear, assert reset after 3 cycles -> IDLE immediately, all registers 0, clear_done never pulses, and a normal write works after reset release.
